// File: rtl/rotate_pkg.sv
// Shared constants for the rotate_operation16 datapath slice.
// Optional flag outputs are gated by the ROT_FLAGS_EN macro in the interface and top.
package rotate_pkg;
  localparam logic ROT_LEFT  = 1'b1;
  localparam logic ROT_RIGHT = 1'b0;
  localparam int   ROT_N     = 16;
endpackage

// File: rtl/rotate_operation16_if.sv
// Operand/result bus for the registered rotator; flag signals exist only with ROT_FLAGS_EN.
interface rotate_operation16_if #(parameter int N = 16);
  localparam int AMT_W = $clog2(N);

  logic             in_valid;
  logic [N-1:0]     data_in;
  logic [AMT_W-1:0] rot_amt;
  logic             rotate_operation;
  logic [N-1:0]     data_out;
  logic             out_valid;
`ifdef ROT_FLAGS_EN
  logic             zero_flag;
  logic             carry_out;
`endif

  modport master (
    output in_valid, data_in, rot_amt, rotate_operation,
`ifdef ROT_FLAGS_EN
    input  zero_flag, carry_out,
`endif
    input  data_out, out_valid
  );

  modport slave (
    input  in_valid, data_in, rot_amt, rotate_operation,
`ifdef ROT_FLAGS_EN
    output zero_flag, carry_out,
`endif
    output data_out, out_valid
  );
endinterface

// File: rtl/rotate_core.sv
// Combinational log2(N)-stage mux barrel rotator; stage i rotates by 2**i when rot_amt[i] is set.
module rotate_core
  import rotate_pkg::*;
#(
  parameter int N     = ROT_N,
  parameter int AMT_W = $clog2(N)
) (
  input  logic [N-1:0]     data,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [N-1:0]     result,
  output logic             carry
);
  logic [AMT_W:0][N-1:0] stg;
  logic                  left;

  assign left   = (dir == ROT_LEFT);
  assign stg[0] = data;

  for (genvar i = 0; i < AMT_W; i++) begin : g_stage
    localparam int S = 1 << i;
    logic [N-1:0] rl, rr;
    assign rl         = {stg[i][N-1-S:0], stg[i][N-1:N-S]};
    assign rr         = {stg[i][S-1:0],   stg[i][N-1:S]};
    assign stg[i+1]   = amt[i] ? (left ? rl : rr) : stg[i];
  end

  assign result = stg[AMT_W];
  // The bit that crossed the boundary last lands at the opposite end of the word.
  assign carry  = (amt != '0) && (left ? result[0] : result[N-1]);
endmodule

// File: rtl/rotate_operation16.sv
// Registered barrel rotator top: direction decode plus output/valid (and optional ROT_FLAGS_EN flag) registers.
module rotate_operation16
  import rotate_pkg::*;
#(
  parameter int N = ROT_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rotate_operation16_if.slave  bus
);
  localparam int AMT_W = $clog2(N);

  logic [N-1:0] rot_res;
  logic         rot_carry;
  logic [N-1:0] data_out_d, data_out_q;
  logic         out_valid_d, out_valid_q;

  rotate_core #(.N(N), .AMT_W(AMT_W)) u_core (
    .data   (bus.data_in),
    .amt    (bus.rot_amt),
    .dir    (bus.rotate_operation),
    .result (rot_res),
    .carry  (rot_carry)
  );

  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) data_out_d = rot_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;

`ifdef ROT_FLAGS_EN
  logic zero_flag_d, zero_flag_q;
  logic carry_out_d, carry_out_q;

  always_comb begin
    zero_flag_d = zero_flag_q;
    carry_out_d = carry_out_q;
    if (bus.in_valid) begin
      zero_flag_d = (rot_res == '0);
      carry_out_d = rot_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag_q <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      zero_flag_q <= zero_flag_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign bus.zero_flag = zero_flag_q;
  assign bus.carry_out = carry_out_q;
`else
  logic unused_carry;
  assign unused_carry = rot_carry;
`endif
endmodule

// File: tb/tb_rotate_operation16.sv
// Directed/table-driven bench for rotate_operation16; flag checks compile in with ROT_FLAGS_EN.
module tb_rotate_operation16;
  import rotate_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rotate_operation16_if #(.N(16)) bus ();
  rotate_operation16 #(.N(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        dir;
    logic [3:0]  amt;
    logic [15:0] din;
    logic [15:0] exp;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] v, input logic [3:0] a, input logic d);
    logic [15:0] r;
    if (a == 0) return v;
    if (d == ROT_LEFT) r = (v << a) | (v >> (16 - a));
    else               r = (v >> a) | (v << (16 - a));
    return r;
  endfunction

  task automatic drive(input logic v, input logic d, input logic [3:0] a, input logic [15:0] x);
    bus.in_valid         = v;
    bus.rotate_operation = d;
    bus.rot_amt          = a;
    bus.data_in          = x;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] v, mid;
    logic [3:0]  a;

    vecs[0]  = '{ROT_LEFT,  4'd1,  16'h0008, 16'h0010, 1'b0, 1'b0};
    vecs[1]  = '{ROT_LEFT,  4'd2,  16'h0010, 16'h0040, 1'b0, 1'b0};
    vecs[2]  = '{ROT_RIGHT, 4'd3,  16'h0018, 16'h0003, 1'b0, 1'b0};
    vecs[3]  = '{ROT_RIGHT, 4'd4,  16'h0020, 16'h0002, 1'b0, 1'b0};
    vecs[4]  = '{ROT_LEFT,  4'd1,  16'h8001, 16'h0003, 1'b1, 1'b0};
    vecs[5]  = '{ROT_RIGHT, 4'd15, 16'h0001, 16'h0002, 1'b0, 1'b0};
    vecs[6]  = '{ROT_LEFT,  4'd0,  16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[7]  = '{ROT_RIGHT, 4'd0,  16'hABCD, 16'hABCD, 1'b0, 1'b0};
    vecs[8]  = '{ROT_LEFT,  4'd1,  16'h8000, 16'h0001, 1'b1, 1'b0};
    vecs[9]  = '{ROT_LEFT,  4'd5,  16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{ROT_RIGHT, 4'd1,  16'h0001, 16'h8000, 1'b1, 1'b0};
    vecs[11] = '{ROT_LEFT,  4'd4,  16'h1234, 16'h2341, 1'b1, 1'b0};
    vecs[12] = '{ROT_RIGHT, 4'd4,  16'h1234, 16'h4123, 1'b0, 1'b0};
    vecs[13] = '{ROT_LEFT,  4'd15, 16'h00F0, 16'h0078, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b1, ROT_LEFT, 4'd3, 16'hFFFF);
    #2;
    check("reset_data", 32'(bus.data_out), 32'h0);
    check("reset_valid", 32'(bus.out_valid), 32'h0);
    step();
    check("reset_hold_data", 32'(bus.data_out), 32'h0);
    check("reset_hold_valid", 32'(bus.out_valid), 32'h0);
    drive(1'b0, ROT_LEFT, 4'd0, 16'h0);
    rst_n = 1'b1;

    // Back-to-back vectors, one per cycle.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].dir, vecs[i].amt, vecs[i].din);
      step();
      check($sformatf("vec%0d_data", i), 32'(bus.data_out), 32'(vecs[i].exp));
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'h1);
`ifdef ROT_FLAGS_EN
      check($sformatf("vec%0d_carry", i), 32'(bus.carry_out), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d_zero", i), 32'(bus.zero_flag), 32'(vecs[i].exp_z));
`endif
    end

    // Idle cycle: result holds, valid drops.
    drive(1'b0, ROT_RIGHT, 4'd7, 16'h5555);
    step();
    check("idle_hold_data", 32'(bus.data_out), 32'h0078);
    check("idle_valid", 32'(bus.out_valid), 32'h0);
`ifdef ROT_FLAGS_EN
    check("idle_hold_carry", 32'(bus.carry_out), 32'h0);
    check("idle_hold_zero", 32'(bus.zero_flag), 32'h0);
`endif

    // Random left-then-right with equal amount returns the original.
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      a = 4'($urandom_range(0, 15));
      mid = model(v, a, ROT_LEFT);
      drive(1'b1, ROT_LEFT, a, v);
      step();
      check($sformatf("rnd%0d_left", i), 32'(bus.data_out), 32'(mid));
      drive(1'b1, ROT_RIGHT, a, mid);
      step();
      check($sformatf("rnd%0d_back", i), 32'(bus.data_out), 32'(v));
    end

    // Reset asserted between edges while a sample is being presented.
    drive(1'b1, ROT_LEFT, 4'd1, 16'h0008);
    step();
    check("pre_reset_data", 32'(bus.data_out), 32'h0010);
    drive(1'b1, ROT_LEFT, 4'd2, 16'h0101);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_data", 32'(bus.data_out), 32'h0);
    check("mid_reset_valid", 32'(bus.out_valid), 32'h0);
`ifdef ROT_FLAGS_EN
    check("mid_reset_carry", 32'(bus.carry_out), 32'h0);
    check("mid_reset_zero", 32'(bus.zero_flag), 32'h0);
`endif
    step();
    check("pending_dropped", 32'(bus.data_out), 32'h0);
    drive(1'b0, ROT_LEFT, 4'd2, 16'h0101);
    rst_n = 1'b1;
    step();
    check("post_reset_idle_valid", 32'(bus.out_valid), 32'h0);
    check("post_reset_idle_data", 32'(bus.data_out), 32'h0);
    drive(1'b1, ROT_RIGHT, 4'd8, 16'h1234);
    step();
    check("first_after_reset_data", 32'(bus.data_out), 32'h3412);
    check("first_after_reset_valid", 32'(bus.out_valid), 32'h1);
    drive(1'b0, ROT_LEFT, 4'd0, 16'h0);
    step();
    check("final_valid_low", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
